// File: rtl/hs32_mem_arbiter.sv
// hs32_mem_arbiter: shares one single-port 32-bit SRAM between a Wishbone
// host and the HS32 core.
// Each access is IDLE -> ACCESS -> RESP, three cycles, read or write.
// Optional macro HS32_ARB_ROUNDROBIN_EN: simultaneous requests alternate
// between the two requesters. Without it the host always wins a tie.
// Addresses above the 2^AW-word window never enable the SRAM. Reads from
// such an address return zero, and writes to it are dropped.

module hs32_mem_arbiter #(
    parameter int AW = 9
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    input  logic          core_stb_i,
    input  logic          core_rw_i,
    input  logic [31:0]   core_addr_i,
    input  logic [31:0]   core_dtw_i,
    output logic          core_ack_o,
    output logic [31:0]   core_dtr_o,
    output logic          sram_en_o,
    output logic [3:0]    sram_we_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [31:0]   sram_din_o,
    input  logic [31:0]   sram_dout_i,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_r;
    logic        grant_core_r;   // 1 = current transaction belongs to the core
    logic        last_core_r;    // 1 = most recent grant went to the core
    logic        win_r;          // current address lies inside the SRAM window
    logic        we_r;           // current transaction is a write
    logic [31:0] wbs_hold_r;     // last host read data, shown outside RESP
    logic [31:0] core_hold_r;    // last core read data, shown outside RESP

    logic        host_req_s;
    logic        core_req_s;
    logic        pick_core_s;
    logic        sel_we_s;
    logic        win_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_data_s;
    logic [3:0]  mask_s;
    logic [31:0] rd_data_s;
    logic        unused_s;

    // Byte offset bits are not used for word addressing.
    assign unused_s = ^{wbs_adr_i[1:0], core_addr_i[1:0]};

    // Arbitration and selection of the address, data and mask of the winning requester.
    always_comb begin
        host_req_s  = wbs_cyc_i & wbs_stb_i;
        core_req_s  = core_stb_i;
        pick_core_s = 1'b0;
`ifdef HS32_ARB_ROUNDROBIN_EN
        if (host_req_s && core_req_s) begin
            pick_core_s = ~last_core_r;
        end else begin
            pick_core_s = core_req_s;
        end
`else
        pick_core_s = core_req_s & ~host_req_s;
`endif
        if (pick_core_s) begin
            sel_addr_s = core_addr_i;
            sel_data_s = core_dtw_i;
            sel_we_s   = core_rw_i;
        end else begin
            sel_addr_s = wbs_adr_i;
            sel_data_s = wbs_dat_i;
            sel_we_s   = wbs_we_i;
        end
        win_s = ~|sel_addr_s[31:AW+2];
        if (sel_we_s && win_s) begin
            mask_s = pick_core_s ? 4'b1111 : wbs_sel_i;
        end else begin
            mask_s = 4'b0000;
        end
    end

    // Read data goes straight from the SRAM while in RESP, because the SRAM
    // only drives it during that cycle. At all other times the last captured
    // value is held.
    always_comb begin
        rd_data_s  = win_r ? sram_dout_i : 32'h0000_0000;
        wbs_dat_o  = wbs_hold_r;
        core_dtr_o = core_hold_r;
        if ((state_r == RESP) && !we_r) begin
            if (grant_core_r) begin
                core_dtr_o = rd_data_s;
            end else begin
                wbs_dat_o = rd_data_s;
            end
        end else begin
            wbs_dat_o  = wbs_hold_r;
            core_dtr_o = core_hold_r;
        end
    end

    // Access sequencer: grant in IDLE, strobe the SRAM in ACCESS, acknowledge in RESP.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r      <= IDLE;
            grant_core_r <= 1'b0;
            last_core_r  <= 1'b1;
            win_r        <= 1'b0;
            we_r         <= 1'b0;
            wbs_hold_r   <= 32'h0000_0000;
            core_hold_r  <= 32'h0000_0000;
            wbs_ack_o    <= 1'b0;
            core_ack_o   <= 1'b0;
            sram_en_o    <= 1'b0;
            sram_we_o    <= 4'b0000;
            sram_addr_o  <= {AW{1'b0}};
            sram_din_o   <= 32'h0000_0000;
            busy_o       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (host_req_s || core_req_s) begin
                        state_r      <= ACCESS;
                        grant_core_r <= pick_core_s;
                        last_core_r  <= pick_core_s;
                        win_r        <= win_s;
                        we_r         <= sel_we_s;
                        sram_en_o    <= win_s;
                        sram_we_o    <= mask_s;
                        sram_addr_o  <= sel_addr_s[AW+1:2];
                        sram_din_o   <= sel_data_s;
                        busy_o       <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    state_r   <= RESP;
                    sram_en_o <= 1'b0;
                    sram_we_o <= 4'b0000;
                    if (grant_core_r) begin
                        core_ack_o <= 1'b1;
                    end else begin
                        wbs_ack_o <= 1'b1;
                    end
                end
                RESP: begin
                    state_r    <= IDLE;
                    wbs_ack_o  <= 1'b0;
                    core_ack_o <= 1'b0;
                    busy_o     <= 1'b0;
                    if (!we_r) begin
                        if (grant_core_r) begin
                            core_hold_r <= rd_data_s;
                        end else begin
                            wbs_hold_r <= rd_data_s;
                        end
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    wbs_ack_o  <= 1'b0;
                    core_ack_o <= 1'b0;
                    sram_en_o  <= 1'b0;
                    sram_we_o  <= 4'b0000;
                    busy_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/hs32_mem_arbiter.md
HS32_MEM_ARBITER -- requirements
Module: hs32_mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 9, meaning SRAM word-address width (2^AW 32-bit words).
REQ-002 The block SHALL have these ports:
- wb_clk_i, in, 1, sole clock; all state changes on rising edge.
- wb_rst_ni, in, 1, asynchronous active-low reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i, in, 1 each, host Wishbone classic cycle, strobe and write enable.
- wbs_sel_i, in, 4, host byte lanes.
- wbs_adr_i, in, 32, host byte address.
- wbs_dat_i, in, 32, host write data.
- wbs_ack_o, out, 1, host acknowledge.
- wbs_dat_o, out, 32, host read data.
- core_stb_i, in, 1, core request.
- core_rw_i, in, 1, core direction; 1 = write.
- core_addr_i, in, 32, core byte address.
- core_dtw_i, in, 32, core write data.
- core_ack_o, out, 1, core acknowledge.
- core_dtr_o, out, 32, core read data.
- sram_en_o, out, 1, SRAM enable.
- sram_we_o, out, 4, SRAM byte write mask.
- sram_addr_o, out, AW, SRAM word address.
- sram_din_o, out, 32, SRAM write data.
- sram_dout_i, in, 32, SRAM read data, valid the cycle after the enabled edge.
- busy_o, out, 1, high whenever the FSM is not in IDLE.

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-004 A host request is wbs_cyc_i & wbs_stb_i; a core request is core_stb_i; both are sampled only in IDLE.
REQ-005 In IDLE with at least one request at edge N, the FSM SHALL register the grant, SRAM address, data and write mask and enter ACCESS.
REQ-006 In ACCESS, sram_en_o SHALL be high for exactly one cycle; at edge N+1 the FSM SHALL enter RESP.
REQ-007 In RESP, the granted requester's ack SHALL be high for exactly one cycle, with read data equal to sram_dout_i; at edge N+2 the FSM SHALL return to IDLE.
REQ-008 Every access (read or write) SHALL take 3 cycles, giving a maximum throughput of one access per 3 cycles.
REQ-009 SRAM address SHALL be adr[AW+1:2].
REQ-010 Host write mask SHALL be wbs_sel_i; core write mask SHALL be 4'b1111; reads SHALL use mask 4'b0000.
REQ-011 An address with any bit in [31:AW+2] set is out of window and SHALL be handled as follows:
- sram_en_o stays low.
- Timing is the same 3 cycles.
- Acknowledged read data is 32'h0.
- Writes are discarded.
REQ-012 The non-granted requester's ack SHALL stay low; its request SHALL remain pending until a later IDLE grant.
REQ-013 If wbs_cyc_i drops during ACCESS or RESP, the SRAM access SHALL still complete, and wbs_ack_o SHALL still pulse in RESP; the host ignores it.
REQ-014 Outputs of the non-granted side SHALL hold their last values; read-data outputs SHALL change only in RESP.
REQ-015 busy_o SHALL be high in ACCESS and RESP.

Reset
REQ-016 Asserting wb_rst_ni low SHALL immediately, without waiting for a clock edge, do all of the following:
- Force state to IDLE.
- Clear all acks, sram_en_o, sram_we_o and busy_o.
- Zero wbs_dat_o, core_dtr_o, sram_addr_o and sram_din_o.
- Set the last-grant register to "core".
REQ-017 A transaction interrupted by reset SHALL be abandoned with no ack.
REQ-018 Requests SHALL be sampled starting with the first rising edge after release.

Configuration
REQ-019 With HS32_ARB_ROUNDROBIN_EN defined, simultaneous requests in IDLE SHALL be granted to the requester not granted last; after reset the host wins first.
REQ-020 Without HS32_ARB_ROUNDROBIN_EN, the host SHALL always win simultaneous requests, and the core may starve under continuous host traffic.

Verification
REQ-021 Host write 32'hCAFEBABE at adr 0x10 with sel 4'b1111, then host read of 0x10 -> ack 2 cycles after request edge; read data 32'hCAFEBABE; SRAM word 4 written.
REQ-022 Host write 32'h11223344 at adr 0x0 with sel 4'b0101 over prior 32'hFFFFFFFF, then core read of 0x0 -> core_dtr_o 32'hFF22FF44.
REQ-023 Host and core requests on the same edge, four times back-to-back:
- With macro: grants alternate host, core, host, core.
- Without macro: all four grants go to the host while its request stays high.
REQ-024 Core read of 0x0000FF00 with AW=9 -> sram_en_o never high; core_ack_o after 2 cycles; data 32'h0.
REQ-025 wb_rst_ni pulled low during ACCESS of a host write -> no ack; busy_o low immediately; the next request after release is granted normally.
